vga_pixel_fetch: RTL and testbench
==================================

Name: vga_pixel_fetch

Overview:
- Streaming prefetcher between the data memory video read port and the VGA output stage.
- Walks a 256x256, 8-bit framebuffer in raster order and issues read addresses on video_address.
- Captures the returned bytes into a small show-ahead FIFO.
- Hands one pixel per pix_req to the VGA pixel pipeline, decoupling display timing from memory read latency. The buffer selection comes from image_select.

Parameters:
- IMG_W, 256, pixels per line
- IMG_H, 256, lines per frame
- ADDR_W, 32, video address width
- BASE0, 0, framebuffer base when image_select=0
- BASE1, 65536, framebuffer base when image_select=1
- FIFO_DEPTH, 8, pixel FIFO entries (power of 2)
- RD_LAT, 1, memory read latency in cycles (address registered to data valid)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- image_select  in  1  framebuffer select, sampled on frame_start
- frame_start  in  1  one-cycle pulse: begin new frame (from VGA timing, at vsync)
- pix_req  in  1  consumer takes one pixel this cycle
- mem_rdata  in  8  data memory video port read data
- video_address  out  ADDR_W  data memory video port read address
- pix_data  out  8  current FIFO head pixel
- pix_valid  out  1  FIFO non-empty
- underflow  out  1  sticky: pix_req seen while pix_valid=0
- frame_done  out  1  one-cycle pulse: last pixel of frame consumed

Behaviour:
- Reset is asynchronous, active-low. All outputs are 0, state is IDLE, the FIFO is empty, all counters are 0 and the in-flight pipe is clear.
- States and transitions:
  - IDLE -> FILL on frame_start.
  - FILL -> RUN when the FIFO is full or issue_cnt = IMG_W*IMG_H.
  - RUN -> DONE when pop_cnt = IMG_W*IMG_H.
  - DONE -> IDLE next cycle.
  - frame_start in any state -> FILL.
- On frame_start:
  - Latch base = image_select ? BASE1 : BASE0.
  - Clear issue_cnt and pop_cnt. Flush the FIFO. Clear the in-flight valid pipe, so returns from the previous frame are dropped.
  - The underflow flag is cleared.
- Issue rule, FILL/RUN:
  - A read issues in a cycle when issue_cnt < IMG_W*IMG_H and (fifo_count + inflight) < FIFO_DEPTH.
  - On issue, video_address <= base + issue_cnt (registered), issue_cnt++, and a valid bit enters an RD_LAT-deep shift pipe.
  - When not issuing, video_address holds its value.
- Return: when the valid bit exits the pipe, mem_rdata is written to the FIFO tail that cycle. The credit rule guarantees no overflow.
- Show-ahead output:
  - pix_data = FIFO head when pix_valid=1, otherwise 0.
  - pix_valid = (fifo_count != 0), registered-equivalent, with no combinational path from pix_req.
- Pop: pix_req and pix_valid pops the head and increments pop_cnt. The next pixel is visible the following cycle.
- Simultaneous push and pop: fifo_count is unchanged and both operations succeed, including when full and when count=1.
- Underflow: pix_req and not pix_valid sets underflow, which stays set until frame_start or reset. Nothing pops and pop_cnt is unchanged.
- pix_req in IDLE/DONE is ignored for counting but still sets underflow.
- End of frame: the final pop drives frame_done=1 for exactly one cycle, then DONE -> IDLE. No issue happens beyond IMG_W*IMG_H.
- Timing: initial fill latency is RD_LAT+1 cycles from frame_start to the first pix_valid. Sustained throughput is 1 pixel/cycle.
- Widths: counters are 17 bits (0..65536). The address add is ADDR_W-bit and wraps modulo 2^ADDR_W.

Test Plan:
- Reset, then frame_start with image_select=0 and pix_req=0 -> video_address 0,1,...,7. FIFO fills to 8 and issue stalls. pix_valid=1 at cycle RD_LAT+1 after frame_start. pix_data = byte at address 0.
- image_select=1 with a memory model returning addr[7:0], pix_req held high after fill -> pix_data sequence 0x00,0x01,... with addresses 65536,65537,...; one pixel per cycle with no bubbles; underflow=0.
- Full frame with continuous pix_req -> exactly 65536 pops, last video_address 65535 (select 0), frame_done pulses once, then IDLE and no further issues.
- pix_req asserted at cycle 1 after frame_start (FIFO empty) -> underflow=1 and stays set through the frame; the next frame_start clears it; pop_cnt is unaffected.
- frame_start asserted mid-frame with a read in flight, select toggled 0->1 -> the stale return is dropped, FIFO flushed, the next address issued is 65536, and the first pixel is from the new base.
- Reset asserted mid-RUN -> outputs go to 0 immediately (asynchronous). After release, nothing issues until frame_start.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// Raster-order framebuffer prefetcher: issues video read addresses, captures the
// returned bytes into a show-ahead FIFO and hands one pixel per pix_req to the VGA pipe.
module vga_pixel_fetch #(
  parameter int unsigned IMG_W      = 256,
  parameter int unsigned IMG_H      = 256,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BASE0      = 0,
  parameter int unsigned BASE1      = 65536,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              image_select,
  input  logic              frame_start,
  input  logic              pix_req,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] video_address,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic              frame_done
);

  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW   = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]       pop_cnt_q, pop_cnt_d;
  logic [RD_LAT-1:0]   pipe_q, pipe_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic                underflow_q, underflow_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          fifo_mem_q [FIFO_DEPTH];

  logic                active, has_data, push, pop, issue;
  int unsigned         inflight;

  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight += 32'(pipe_q[i]);

    active   = (state_q == FILL) || (state_q == RUN);
    has_data = (fifo_cnt_q != '0);
    // frame_start outranks everything: the stale return and any pop are discarded
    push     = pipe_q[RD_LAT-1] && !frame_start;
    pop      = pix_req && has_data && active && !frame_start;
    issue    = active && !frame_start && (issue_cnt_q < CW'(TOTAL)) &&
               ((32'(fifo_cnt_q) + inflight) < FIFO_DEPTH);

    state_d      = state_q;
    base_d       = base_q;
    addr_d       = addr_q;
    issue_cnt_d  = issue_cnt_q;
    pop_cnt_d    = pop_cnt_q;
    pipe_d       = '0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;
    underflow_d  = underflow_q | (pix_req & ~has_data);
    frame_done_d = 1'b0;

    if (frame_start) begin
      state_d     = FILL;
      base_d      = image_select ? ADDR_W'(BASE1) : ADDR_W'(BASE0);
      issue_cnt_d = '0;
      pop_cnt_d   = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fifo_cnt_d  = '0;
      underflow_d = 1'b0;
    end else begin
      pipe_d[0] = issue;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

      if (issue) begin
        addr_d      = base_q + ADDR_W'(issue_cnt_q);
        issue_cnt_d = issue_cnt_q + 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        pop_cnt_d = pop_cnt_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
        default: fifo_cnt_d = fifo_cnt_q;
      endcase

      unique case (state_q)
        IDLE: state_d = IDLE;
        FILL: if (fifo_cnt_q == FCW'(FIFO_DEPTH) || issue_cnt_q == CW'(TOTAL)) state_d = RUN;
        RUN:  state_d = RUN;
        DONE: state_d = IDLE;
      endcase
      if (pop && pop_cnt_q == CW'(TOTAL - 1)) begin
        state_d      = DONE;
        frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      addr_q       <= '0;
      issue_cnt_q  <= '0;
      pop_cnt_q    <= '0;
      pipe_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      addr_q       <= addr_d;
      issue_cnt_q  <= issue_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      pipe_q       <= pipe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= mem_rdata;
  end

  assign video_address = addr_q;
  assign pix_valid     = has_data;
  assign pix_data      = has_data ? fifo_mem_q[rd_ptr_q] : '0;
  assign underflow     = underflow_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch; memory model returns addr[7:0], XORed with
// mem_xor for buffer 0 so stale/new-base data can be told apart.
module tb_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        image_select;
  logic        frame_start;
  logic        pix_req;
  logic [7:0]  mem_rdata;
  logic [31:0] video_address;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        underflow;
  logic        frame_done;
  logic [7:0]  mem_xor;

  int errors = 0;
  int checks = 0;

  vga_pixel_fetch #(
    .IMG_W(256), .IMG_H(256), .ADDR_W(32), .BASE0(0), .BASE1(65536),
    .FIFO_DEPTH(8), .RD_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .image_select(image_select), .frame_start(frame_start),
    .pix_req(pix_req), .mem_rdata(mem_rdata), .video_address(video_address),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign mem_rdata = video_address[7:0] ^ (video_address[16] ? 8'h00 : mem_xor);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic sel);
    image_select = sel;
    frame_start  = 1'b1;
    tick();
    frame_start  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; image_select = 1'b0; frame_start = 1'b0; pix_req = 1'b0; mem_xor = 8'h00;
    tick(); tick();
    checks++;
    if ({video_address, pix_data, pix_valid, underflow, frame_done} !== 43'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d data=%h valid=%b uf=%b done=%b, want all 0",
               video_address, pix_data, pix_valid, underflow, frame_done);
    end
    #3 reset = 1'b1;
    repeat (5) tick();
    checks++;
    if (video_address !== 32'd0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_issue: got addr=%0d valid=%b, want 0 0", video_address, pix_valid);
    end
  endtask

  task automatic test_fill;
    mem_xor = 8'h3C;
    start_frame(1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (video_address !== 32'(k - 1)) begin
        errors++;
        $display("FAIL fill_addr_%0d: got %0d, want %0d", k, video_address, k - 1);
      end
      if (k == 1) begin
        checks++;
        if (pix_valid !== 1'b0) begin
          errors++;
          $display("FAIL fill_latency_early: got valid=%b, want 0", pix_valid);
        end
      end
      if (k == 2) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== 8'h3C) begin
          errors++;
          $display("FAIL fill_first_pixel: got valid=%b data=%h, want 1 3c", pix_valid, pix_data);
        end
      end
    end
    repeat (4) tick();
    checks++;
    if (video_address !== 32'd7 || pix_valid !== 1'b1 || pix_data !== 8'h3C) begin
      errors++;
      $display("FAIL fill_stall: got addr=%0d valid=%b data=%h, want 7 1 3c",
               video_address, pix_valid, pix_data);
    end
  endtask

  task automatic test_stream_sel1;
    int bad = 0;
    start_frame(1'b1);
    repeat (12) tick();
    checks++;
    if (video_address !== 32'd65543) begin
      errors++;
      $display("FAIL sel1_fill_addr: got %0d, want 65543", video_address);
    end
    pix_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (pix_valid !== 1'b1 || pix_data !== 8'(i)) bad++;
      tick();
    end
    pix_req = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sel1_stream: got %0d bad/bubble cycles of 40, want 0", bad);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL sel1_underflow: got %b, want 0", underflow);
    end
  endtask

  task automatic test_underflow;
    mem_xor = 8'h3C;
    start_frame(1'b0);
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set: got %b, want 1", underflow);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'h3C) begin
      errors++;
      $display("FAIL underflow_no_pop: got valid=%b data=%h, want 1 3c", pix_valid, pix_data);
    end
    pix_req = 1'b1;
    repeat (3) tick();
    pix_req = 1'b0;
    checks++;
    if (underflow !== 1'b1 || pix_data !== 8'h3F) begin
      errors++;
      $display("FAIL underflow_sticky: got uf=%b data=%h, want 1 3f", underflow, pix_data);
    end
    start_frame(1'b0);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: got %b, want 0", underflow);
    end
  endtask

  task automatic test_restart_midframe;
    mem_xor = 8'h5A;
    start_frame(1'b0);
    tick();
    start_frame(1'b1);
    checks++;
    if (pix_valid !== 1'b0 || video_address !== 32'd0) begin
      errors++;
      $display("FAIL restart_flush: got valid=%b addr=%0d, want 0 0", pix_valid, video_address);
    end
    tick();
    checks++;
    if (video_address !== 32'd65536 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_addr: got addr=%0d valid=%b, want 65536 0", video_address, pix_valid);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'h00) begin
      errors++;
      $display("FAIL restart_first_pixel: got valid=%b data=%h, want 1 00", pix_valid, pix_data);
    end
  endtask

  task automatic test_full_frame;
    int pops = 0, dones = 0, bad = 0, tail = 0;
    logic seen = 1'b0;
    mem_xor = 8'h00;
    start_frame(1'b0);
    tick(); tick();
    pix_req = 1'b1;
    for (int c = 0; c < 66000 && tail < 20; c++) begin
      if (frame_done === 1'b1) begin
        dones++;
        seen = 1'b1;
        pix_req = 1'b0;
      end
      if (seen) tail++;
      if (pix_valid === 1'b1 && pix_req === 1'b1) begin
        if (pix_data !== 8'(pops)) bad++;
        pops++;
      end
      tick();
    end
    pix_req = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_timeout: frame_done never seen within 66000 cycles");
    end
    checks++;
    if (pops != 65536) begin
      errors++;
      $display("FAIL frame_pops: got %0d, want 65536", pops);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL frame_done_pulses: got %0d, want 1", dones);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_data: got %0d wrong pixels, want 0", bad);
    end
    checks++;
    if (video_address !== 32'd65535 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_end_idle: got addr=%0d valid=%b, want 65535 0", video_address, pix_valid);
    end
  endtask

  task automatic test_reset_midrun;
    start_frame(1'b1);
    pix_req = 1'b1;
    tick();
    repeat (10) tick();
    pix_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({video_address, pix_data, pix_valid, underflow, frame_done} !== 43'd0) begin
      errors++;
      $display("FAIL async_reset: got addr=%0d data=%h valid=%b uf=%b done=%b, want all 0",
               video_address, pix_data, pix_valid, underflow, frame_done);
    end
    tick();
    #2 reset = 1'b1;
    repeat (10) tick();
    checks++;
    if (video_address !== 32'd0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got addr=%0d valid=%b, want 0 0", video_address, pix_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream_sel1();
    test_underflow();
    test_restart_midframe();
    test_full_frame();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
